// File: rtl/keypad_kbd_pkg.sv
// Shared types and constants for the keypad-to-Hack-KBD bridge.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } kbd_state_t;

  localparam logic [15:0] KBD_ADDR = 16'h6000;

  // Key index 0 sits in the least-significant byte: "123A456B789C*0#D".
  localparam logic [16*8-1:0] KEY_MAP = {
    8'h44, 8'h23, 8'h30, 8'h2A,
    8'h43, 8'h39, 8'h38, 8'h37,
    8'h42, 8'h36, 8'h35, 8'h34,
    8'h41, 8'h33, 8'h32, 8'h31
  };

  function automatic logic [7:0] key_ascii(input logic [3:0] idx);
    return KEY_MAP[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Small FIFO of translated ASCII key events; a push while full is accepted only alongside a pop.
module keypad_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/keypad_kbd.sv
// Keypad event to Hack KBD register: hold each code, then force a zero gap.
// Define KEYPAD_KBD_FIFO_EN to queue events that arrive during HOLD/GAP.
module keypad_kbd
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2500000,
  parameter int GAP_CYCLES  = 250000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   key_index,
  input  logic                         key_valid,
  output logic [15:0]                  kbd_code,
  output logic                         kbd_busy,
  output logic [$clog2(FIFO_DEPTH):0]  pending,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  kbd_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [15:0]   code_reg, code_next;
  logic          busy_reg;
  logic          overflow_reg;

  logic          ev_avail;
  logic [7:0]    ev_ascii;
  logic          drop;

`ifdef KEYPAD_KBD_FIFO_EN
  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_full;

  assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;
  assign ev_avail = !fifo_empty;
  assign ev_ascii = fifo_dout;
  assign drop     = key_valid && fifo_full && !fifo_pop;

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (key_valid),
    .din   (key_ascii(key_index)),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (pending)
  );
`else
  // Without storage an event is only usable if it lands while IDLE.
  assign ev_avail = key_valid;
  assign ev_ascii = key_ascii(key_index);
  assign drop     = key_valid && (state_reg != ST_IDLE);
  assign pending  = '0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ev_avail) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
          code_next  = {8'h00, ev_ascii};
        end
      end
      ST_HOLD: begin
        if (cnt_reg == '0) begin
          state_next = ST_GAP;
          cnt_next   = GAP_LOAD;
          code_next  = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        code_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      code_reg     <= '0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
      busy_reg  <= (state_next != ST_IDLE);
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign kbd_code = code_reg;
  assign kbd_busy = busy_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_keypad_kbd.sv
// Directed bench for keypad_kbd; follows KEYPAD_KBD_FIFO_EN to pick the build-specific sequences.
module tb_keypad_kbd;

  localparam int H     = 4;
  localparam int G     = 2;
  localparam int DEPTH = 4;
`ifdef KEYPAD_KBD_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_index = '0;
  logic        key_valid = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] kbd_code;
  logic        kbd_busy;
  logic [$clog2(DEPTH):0] pending;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] code;
  } vec_t;

  vec_t vecs[16];

  keypad_kbd #(
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_index (key_index),
    .key_valid (key_valid),
    .kbd_code  (kbd_code),
    .kbd_busy  (kbd_busy),
    .pending   (pending),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Strobe one key and measure latency, hold length and gap length.
  task automatic press_and_check(input logic [3:0] idx, input logic [15:0] exp);
    int lat, hold, gap;
    key_index = idx;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    lat = 0;
    while (kbd_code == 16'h0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("lat[%0d]", idx), lat, LAT);
    chk($sformatf("code[%0d]", idx), {16'h0, kbd_code}, {16'h0, exp});
    hold = 0;
    while (kbd_code != 16'h0 && hold < 20) begin
      hold++;
      @(negedge clk);
    end
    chk($sformatf("hold[%0d]", idx), hold, H);
    gap = 0;
    while (kbd_code == 16'h0 && kbd_busy && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    chk($sformatf("gap[%0d]", idx), gap, G);
  endtask

  // Wait for the next non-zero code, compare it, then wait for it to drop.
  task automatic get_code(input string name, input logic [15:0] exp);
    int w;
    w = 0;
    while (kbd_code == 16'h0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk(name, {16'h0, kbd_code}, {16'h0, exp});
    w = 0;
    while (kbd_code != 16'h0 && w < 40) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (kbd_code != 16'h0) seen = 1'b1;
      @(negedge clk);
    end
    chk(name, {31'h0, seen}, 32'h0);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (kbd_busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("wait_idle", {31'h0, kbd_busy}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{4'd0,  16'h0031};
    vecs[1]  = '{4'd1,  16'h0032};
    vecs[2]  = '{4'd2,  16'h0033};
    vecs[3]  = '{4'd3,  16'h0041};
    vecs[4]  = '{4'd4,  16'h0034};
    vecs[5]  = '{4'd5,  16'h0035};
    vecs[6]  = '{4'd6,  16'h0036};
    vecs[7]  = '{4'd7,  16'h0042};
    vecs[8]  = '{4'd8,  16'h0037};
    vecs[9]  = '{4'd9,  16'h0038};
    vecs[10] = '{4'd10, 16'h0039};
    vecs[11] = '{4'd11, 16'h0043};
    vecs[12] = '{4'd12, 16'h002A};
    vecs[13] = '{4'd13, 16'h0030};
    vecs[14] = '{4'd14, 16'h0023};
    vecs[15] = '{4'd15, 16'h0044};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_code", {16'h0, kbd_code}, 32'h0);
    chk("rst_busy", {31'h0, kbd_busy}, 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Map sweep, one isolated press per key
    for (int i = 0; i < 16; i++) begin
      press_and_check(vecs[i].idx, vecs[i].code);
      @(negedge clk);
    end

`ifdef KEYPAD_KBD_FIFO_EN
    // Burst of 6: the 6th is dropped, and its ovf_clr loses to the set
    for (int k = 0; k < 6; k++) begin
      key_index = 4'(k);
      key_valid = 1'b1;
      ovf_clr   = (k == 5);
      @(negedge clk);
      if (k == 1) chk("burst_0", {16'h0, kbd_code}, 32'h0031);
    end
    key_valid = 1'b0;
    ovf_clr   = 1'b0;
    chk("burst_ovf", {31'h0, overflow}, 32'h1);
    chk("burst_pending", 32'(pending), 32'h4);
    get_code("burst_1", 16'h0032);
    get_code("burst_2", 16'h0033);
    get_code("burst_3", 16'h0041);
    get_code("burst_4", 16'h0034);
    watch_quiet("burst_no6th", 3 * (H + G + 2));
    chk("burst_drained", 32'(pending), 32'h0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);

    // Full FIFO: a push in the same cycle as a pop is accepted
    for (int k = 1; k <= 5; k++) begin
      key_index = 4'(k);
      key_valid = 1'b1;
      @(negedge clk);
    end
    key_valid = 1'b0;
    wait_idle();
    chk("full_pending", 32'(pending), 32'h4);
    key_index = 4'd6;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("fullpop_ovf", {31'h0, overflow}, 32'h0);
    chk("fullpop_pending", 32'(pending), 32'h4);
    get_code("fullpop_1", 16'h0033);
    get_code("fullpop_2", 16'h0041);
    get_code("fullpop_3", 16'h0034);
    get_code("fullpop_4", 16'h0035);
    get_code("fullpop_5", 16'h0036);
    wait_idle();

    // Repeated key 13 queued behind itself: gap plus one idle cycle of zero
    begin
      int w, zc;
      key_index = 4'd13;
      key_valid = 1'b1;
      repeat (2) @(negedge clk);
      key_valid = 1'b0;
      chk("repeat_first", {16'h0, kbd_code}, 32'h0030);
      w = 0;
      while (kbd_code != 16'h0 && w < 20) begin
        @(negedge clk);
        w++;
      end
      zc = 0;
      while (kbd_code == 16'h0 && zc < 20) begin
        zc++;
        @(negedge clk);
      end
      chk("repeat_zero_len", zc, G + 1);
      chk("repeat_second", {16'h0, kbd_code}, 32'h0030);
      wait_idle();
    end
`else
    // No storage: a strobe during HOLD is dropped even with ovf_clr high
    key_index = 4'd0;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("nofifo_first", {16'h0, kbd_code}, 32'h0031);
    key_index = 4'd1;
    key_valid = 1'b1;
    ovf_clr   = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    ovf_clr   = 1'b0;
    chk("nofifo_ovf", {31'h0, overflow}, 32'h1);
    chk("nofifo_pending", 32'(pending), 32'h0);
    begin
      int w;
      w = 0;
      while (kbd_code != 16'h0 && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    watch_quiet("nofifo_no_second", 20);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);
`endif

    // Reset mid-hold, with two events queued in the FIFO build
    for (int k = 7; k <= 9; k++) begin
      key_index = 4'(k);
      key_valid = 1'b1;
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("prerst_busy", {31'h0, kbd_busy}, 32'h1);
`ifdef KEYPAD_KBD_FIFO_EN
    chk("prerst_pending", 32'(pending), 32'h2);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_code", {16'h0, kbd_code}, 32'h0);
    chk("midrst_pending", 32'(pending), 32'h0);
    chk("midrst_busy", {31'h0, kbd_busy}, 32'h0);
    chk("midrst_overflow", {31'h0, overflow}, 32'h0);
    rst_n = 1'b1;
    watch_quiet("postrst_no_stale", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
